// File: rtl/gemm_result_writer_if.sv
// ---------------------------------------------------------------------------
// gemm_result_writer_if
// Bundles every signal of the GeMM result writeback stage except clock and
// reset.
//   master : environment side. It presents tiles and the controller done
//            pulse, answers SRAM grants and observes writer status.
//   slave  : writer side. It accepts tiles, drives the SRAM write request
//            and reports status.
// Signal groups:
//   result_valid_i / result_data_i / tile_m_i / tile_n_i / N_size_i  tile capture
//   ctrl_done_i                                                      controller done
//   sram_req_o / sram_gnt_i / sram_addr_o / sram_wdata_o             SRAM write port
//   busy_o / done_o / overflow_o / fill_o                            status
// ---------------------------------------------------------------------------
interface gemm_result_writer_if #(
  parameter int DataWidth = 32,
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int AddrWidth = 8,
  parameter int FifoDepth = 4
);
  localparam int TileW  = M * N * DataWidth;
  localparam int MW     = AddrWidth - $clog2(M);
  localparam int NW     = AddrWidth - $clog2(N);
  localparam int NSizeW = $clog2(32) + 1;
  localparam int CntW   = $clog2(FifoDepth) + 1;

  logic                 result_valid_i;
  logic [TileW-1:0]     result_data_i;
  logic [MW-1:0]        tile_m_i;
  logic [NW-1:0]        tile_n_i;
  logic [NSizeW-1:0]    N_size_i;
  logic                 ctrl_done_i;
  logic                 sram_req_o;
  logic                 sram_gnt_i;
  logic [AddrWidth-1:0] sram_addr_o;
  logic [TileW-1:0]     sram_wdata_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 overflow_o;
  logic [CntW-1:0]      fill_o;

  modport slave (
    input  result_valid_i, result_data_i, tile_m_i, tile_n_i, N_size_i,
    input  ctrl_done_i, sram_gnt_i,
    output sram_req_o, sram_addr_o, sram_wdata_o,
    output busy_o, done_o, overflow_o, fill_o
  );

  modport master (
    output result_valid_i, result_data_i, tile_m_i, tile_n_i, N_size_i,
    output ctrl_done_i, sram_gnt_i,
    input  sram_req_o, sram_addr_o, sram_wdata_o,
    input  busy_o, done_o, overflow_o, fill_o
  );
endinterface

// File: rtl/gemm_result_writer.sv
// ---------------------------------------------------------------------------
// gemm_result_writer
// Writeback stage behind the GeMM controller and MAC array. Each completed
// M x N tile is captured with its tile-granular SRAM address into a small
// FIFO. The tile is then written out over a req/gnt port, and the
// controller's done pulse becomes a writer done that fires only after the
// FIFO has drained.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset. It clears state, FIFO contents
//          and the sticky overflow flag.
//   bus    gemm_result_writer_if.slave. Carries tile capture, SRAM write
//          port and status.
// All outputs come straight from registers; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module gemm_result_writer #(
  parameter int DataWidth = 32,
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int AddrWidth = 8,
  parameter int FifoDepth = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  gemm_result_writer_if.slave  bus
);

  localparam int TileW  = M * N * DataWidth;
  localparam int PtrW   = $clog2(FifoDepth);
  localparam int CntW   = PtrW + 1;
  localparam int MW     = AddrWidth - $clog2(M);
  localparam int NW     = AddrWidth - $clog2(N);
  localparam int NSizeW = $clog2(32) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Tile address: row index times tiles-per-row plus column index. All
  // arithmetic is modulo 2^AddrWidth, so truncating the operands first
  // yields the same low bits as the full-width product.
  function automatic logic [AddrWidth-1:0] tile_addr(
    input logic [MW-1:0]     m,
    input logic [NW-1:0]     n,
    input logic [NSizeW-1:0] nsize
  );
    logic [NSizeW-1:0] tiles_per_row;
    tiles_per_row = nsize / NSizeW'(N);
    return AddrWidth'(m) * AddrWidth'(tiles_per_row) + AddrWidth'(n);
  endfunction

  logic [AddrWidth-1:0] addr_mem [FifoDepth];
  logic [TileW-1:0]     data_mem [FifoDepth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count;
  logic [CntW-1:0]      count_next;
  logic                 overflow;
  state_t               state;
  state_t               state_next;

  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [AddrWidth-1:0] cap_addr;

  always_comb begin
    empty      = (count == '0);
    full       = (count == FullCnt);
    pop        = !empty && bus.sram_gnt_i;
    // A full FIFO still takes a tile when the head leaves in the same cycle.
    push       = bus.result_valid_i && (!full || pop);
    drop       = bus.result_valid_i && full && !pop;
    count_next = count + CntW'(push) - CntW'(pop);
    cap_addr   = tile_addr(bus.tile_m_i, bus.tile_n_i, bus.N_size_i);
  end

  // ---- capture / FIFO storage ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= cap_addr;
        data_mem[wr_ptr] <= bus.result_data_i;
        wr_ptr           <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      count <= count_next;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---- control FSM: state register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // ---- control FSM: next state ----
  // Flush exits on post-update occupancy. The cycle of the last grant
  // therefore leads directly into Done.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (bus.ctrl_done_i) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (count_next == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // ---- registered outputs ----
  assign bus.sram_req_o   = !empty;
  assign bus.sram_addr_o  = addr_mem[rd_ptr];
  assign bus.sram_wdata_o = data_mem[rd_ptr];
  assign bus.busy_o       = !empty || (state == ST_FLUSH);
  assign bus.done_o       = (state == ST_DONE);
  assign bus.overflow_o   = overflow;
  assign bus.fill_o       = count;

endmodule

// File: tb/tb_gemm_result_writer.sv
// ---------------------------------------------------------------------------
// tb_gemm_result_writer
// Directed bench for gemm_result_writer using default parameters
// (DataWidth=32, M=N=4, AddrWidth=8, FifoDepth=4). Inputs change 1 time unit
// after the rising edge, and outputs are read at that point.
// ---------------------------------------------------------------------------
module tb_gemm_result_writer;

  localparam int DataWidth = 32;
  localparam int M         = 4;
  localparam int N         = 4;
  localparam int AddrWidth = 8;
  localparam int FifoDepth = 4;
  localparam int TileW     = M * N * DataWidth;
  localparam int MW        = AddrWidth - $clog2(M);
  localparam int NW        = AddrWidth - $clog2(N);
  localparam int NSizeW    = $clog2(32) + 1;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;

  gemm_result_writer_if #(
    .DataWidth(DataWidth), .M(M), .N(N), .AddrWidth(AddrWidth), .FifoDepth(FifoDepth)
  ) bus ();

  gemm_result_writer #(
    .DataWidth(DataWidth), .M(M), .N(N), .AddrWidth(AddrWidth), .FifoDepth(FifoDepth)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [TileW-1:0] got, input logic [TileW-1:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Element (r,c) of tile 'seed' holds seed*256 + r*N + c.
  function automatic logic [TileW-1:0] mk_data(input int seed);
    logic [TileW-1:0] d;
    d = '0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        d[(r*N+c)*DataWidth +: DataWidth] = DataWidth'(seed * 256 + r * N + c);
      end
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tile(input int m, input int n, input int seed);
    bus.result_valid_i = 1'b1;
    bus.tile_m_i       = MW'(m);
    bus.tile_n_i       = NW'(n);
    bus.result_data_i  = mk_data(seed);
    step();
    bus.result_valid_i = 1'b0;
  endtask

  initial begin
    pass_cnt           = 0;
    chk_cnt            = 0;
    rst                = 1'b1;
    bus.result_valid_i = 1'b0;
    bus.result_data_i  = '0;
    bus.tile_m_i       = '0;
    bus.tile_n_i       = '0;
    bus.N_size_i       = NSizeW'(16);
    bus.ctrl_done_i    = 1'b0;
    bus.sram_gnt_i     = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_fill",  TileW'(bus.fill_o),      TileW'(0));
    chk("rst_req",   TileW'(bus.sram_req_o),  TileW'(0));
    chk("rst_busy",  TileW'(bus.busy_o),      TileW'(0));
    chk("rst_done",  TileW'(bus.done_o),      TileW'(0));
    chk("rst_ovf",   TileW'(bus.overflow_o),  TileW'(0));
    chk("rst_addr",  TileW'(bus.sram_addr_o), TileW'(0));
    chk("rst_wdata", bus.sram_wdata_o,        TileW'(0));

    // Single tile: 2*(16/4)+3 = 11
    bus.sram_gnt_i = 1'b1;
    push_tile(2, 3, 1);
    chk("single_req",   TileW'(bus.sram_req_o),  TileW'(1));
    chk("single_addr",  TileW'(bus.sram_addr_o), TileW'(11));
    chk("single_data",  bus.sram_wdata_o,        mk_data(1));
    chk("single_fill1", TileW'(bus.fill_o),      TileW'(1));
    step();
    chk("single_fill0", TileW'(bus.fill_o),      TileW'(0));
    chk("single_req0",  TileW'(bus.sram_req_o),  TileW'(0));

    // Backpressure: three tiles at addresses 0,1,2, stalled 5 cycles
    bus.sram_gnt_i = 1'b0;
    push_tile(0, 0, 10);
    chk("bp_addr_c1", TileW'(bus.sram_addr_o), TileW'(0));
    push_tile(0, 1, 11);
    push_tile(0, 2, 12);
    for (int i = 0; i < 2; i++) begin
      chk("bp_stall_addr", TileW'(bus.sram_addr_o), TileW'(0));
      chk("bp_stall_data", bus.sram_wdata_o,        mk_data(10));
      step();
    end
    chk("bp_fill3", TileW'(bus.fill_o), TileW'(3));
    bus.sram_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req",  TileW'(bus.sram_req_o),  TileW'(1));
      chk("bp_addr", TileW'(bus.sram_addr_o), TileW'(i));
      chk("bp_data", bus.sram_wdata_o,        mk_data(10 + i));
      step();
    end
    chk("bp_fill0", TileW'(bus.fill_o),     TileW'(0));
    chk("bp_ovf",   TileW'(bus.overflow_o), TileW'(0));

    // Full FIFO with simultaneous push and pop
    bus.sram_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) push_tile(0, i, 20 + i);
    chk("fp_fill4", TileW'(bus.fill_o), TileW'(4));
    bus.sram_gnt_i = 1'b1;
    push_tile(0, 5, 24);
    chk("fp_fill_hold", TileW'(bus.fill_o),      TileW'(4));
    chk("fp_ovf",       TileW'(bus.overflow_o),  TileW'(0));
    for (int i = 0; i < 4; i++) begin
      chk("fp_drain_addr", TileW'(bus.sram_addr_o), TileW'((i == 3) ? 5 : i + 1));
      chk("fp_drain_data", bus.sram_wdata_o,        mk_data(21 + i));
      step();
    end
    chk("fp_fill0", TileW'(bus.fill_o), TileW'(0));

    // Overflow: 5 back-to-back valids, no grants
    bus.sram_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) push_tile(0, i, 30 + i);
    chk("ov_ovf_pre", TileW'(bus.overflow_o), TileW'(0));
    push_tile(0, 4, 34);
    chk("ov_fill4", TileW'(bus.fill_o),     TileW'(4));
    chk("ov_ovf",   TileW'(bus.overflow_o), TileW'(1));
    bus.sram_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ov_drain_addr", TileW'(bus.sram_addr_o), TileW'(i));
      chk("ov_drain_data", bus.sram_wdata_o,        mk_data(30 + i));
      step();
    end
    chk("ov_req0",    TileW'(bus.sram_req_o), TileW'(0));
    chk("ov_sticky",  TileW'(bus.overflow_o), TileW'(1));

    // Done sequencing with 2 tiles queued
    bus.sram_gnt_i = 1'b0;
    push_tile(1, 0, 40);
    push_tile(1, 1, 41);
    bus.ctrl_done_i = 1'b1;
    bus.sram_gnt_i  = 1'b1;
    step();
    bus.ctrl_done_i = 1'b0;
    chk("dq_fill1", TileW'(bus.fill_o), TileW'(1));
    chk("dq_busy1", TileW'(bus.busy_o), TileW'(1));
    chk("dq_done0", TileW'(bus.done_o), TileW'(0));
    step();
    chk("dq_done1", TileW'(bus.done_o), TileW'(1));
    chk("dq_busy0", TileW'(bus.busy_o), TileW'(0));
    chk("dq_fill0", TileW'(bus.fill_o), TileW'(0));
    step();
    chk("dq_done_pulse", TileW'(bus.done_o), TileW'(0));

    // Done with empty FIFO: done two cycles after ctrl_done
    bus.ctrl_done_i = 1'b1;
    step();
    bus.ctrl_done_i = 1'b0;
    chk("de_flush_busy", TileW'(bus.busy_o), TileW'(1));
    chk("de_done_c1",    TileW'(bus.done_o), TileW'(0));
    step();
    chk("de_done_c2",    TileW'(bus.done_o), TileW'(1));
    step();
    chk("de_done_c3",    TileW'(bus.done_o), TileW'(0));

    // Address arithmetic: wrap (63*4+10 = 262 -> 6) and non-multiple N_size (3*(18/4)+1 = 13)
    push_tile(63, 10, 50);
    chk("addr_wrap", TileW'(bus.sram_addr_o), TileW'(6));
    step();
    bus.N_size_i = NSizeW'(18);
    push_tile(3, 1, 51);
    chk("addr_nsize18", TileW'(bus.sram_addr_o), TileW'(13));
    step();
    bus.N_size_i = NSizeW'(16);

    // Reset mid-drain
    bus.sram_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) push_tile(2, i, 60 + i);
    chk("rm_fill3", TileW'(bus.fill_o), TileW'(3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_fill",  TileW'(bus.fill_o),      TileW'(0));
    chk("rm_req",   TileW'(bus.sram_req_o),  TileW'(0));
    chk("rm_ovf",   TileW'(bus.overflow_o),  TileW'(0));
    chk("rm_busy",  TileW'(bus.busy_o),      TileW'(0));
    chk("rm_addr",  TileW'(bus.sram_addr_o), TileW'(0));
    chk("rm_wdata", bus.sram_wdata_o,        TileW'(0));
    // Back in Run: a fresh ctrl_done goes through Flush to Done
    bus.ctrl_done_i = 1'b1;
    step();
    bus.ctrl_done_i = 1'b0;
    chk("rm_run_c1", TileW'(bus.done_o), TileW'(0));
    step();
    chk("rm_run_c2", TileW'(bus.done_o), TileW'(1));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
